spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter MISO_DLY, default 1, number of idle cycles between the last MOSI bit and the first MISO sample (range 0-15).
REQ-002 Parameter GAP, default 1, minimum cycles SS_n is held high between frames (range 1-15).
REQ-003 clk  input  1  system clock; all logic on rising edge; the slave shares this clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle frame request; accepted only when busy=0.
REQ-006 cmd_data  input  10  frame word {cmd[1:0], payload[7:0]}; 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-007 busy  output  1  high whenever FSM is not IDLE.
REQ-008 done  output  1  one-cycle pulse at frame end.
REQ-009 rd_data  output  8  byte received on MISO for cmd 11; holds until the next rd-data frame or reset.
REQ-010 rd_valid  output  1  one-cycle pulse, coincident with done, for cmd 11 only.
REQ-011 SS_n  output  1  active-low slave select.
REQ-012 MOSI  output  1  serial data to slave.
REQ-013 MISO  input  1  serial data from slave.

Function
REQ-014 The FSM SHALL have states IDLE, CMD, SHIFT_OUT, WAIT, SHIFT_IN and GAP, all encoded registered with no latches.
REQ-015 In IDLE with start=1 at edge E0, the block SHALL latch cmd_data and enter CMD; start while busy=1 SHALL be ignored with no queuing.
REQ-016 CMD (1 cycle after E0) SHALL drive SS_n=0, MOSI=cmd_data[9] (path-select lead bit).
REQ-017 SHIFT_OUT SHALL follow for 10 cycles driving MOSI=cmd_data[9] down to cmd_data[0], MSB first, one bit per cycle, SS_n=0; MOSI changes only on rising edges.
REQ-018 For cmd 00, 01 or 10, after the 10th bit the FSM SHALL enter GAP; total SS_n-low time is exactly 11 cycles.
REQ-019 For cmd 11, after the 10th bit the FSM SHALL enter WAIT for MISO_DLY cycles (skipped if 0) with SS_n=0, MOSI=0.
REQ-020 SHIFT_IN SHALL last 8 cycles and sample MISO on each rising edge, MSB first, into a shift register; SS_n=0, MOSI=0.
REQ-021 On the 8th sampling edge the block SHALL load rd_data and enter GAP.
REQ-022 GAP SHALL hold SS_n=1, MOSI=0 for GAP cycles and then return to IDLE; done (and rd_valid for cmd 11) SHALL be high in the first GAP cycle only.
REQ-023 busy SHALL be 1 from the cycle after E0 through the last GAP cycle inclusive; start held high continuously SHALL produce back-to-back frames separated by exactly GAP SS_n-high cycles plus one IDLE cycle.
REQ-024 A change on cmd_data during a frame SHALL NOT affect the frame in progress.
REQ-025 In IDLE: SS_n=1, MOSI=0, done=0, rd_valid=0.

Reset
REQ-026 With rst=1 at a rising edge, all state SHALL be cleared by the next cycle: state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, counters=0.
REQ-027 rst SHALL take priority over start; reset mid-frame SHALL abort the frame with no done or rd_valid pulse.

Verification
REQ-028 start with cmd_data=10'h0AB -> SS_n low 11 cycles; MOSI = 0,0,0,1,0,1,0,1,0,1,1; done pulses once; rd_valid=0.
REQ-029 start with cmd_data=10'h352 while a slave model returns 8'hA5 on MISO after MISO_DLY=1 -> SS_n low 20 cycles; rd_data=8'hA5; rd_valid and done high together for one cycle.
REQ-030 Same as REQ-029 with MISO_DLY=0 -> SS_n low 19 cycles; rd_data=8'hA5.
REQ-031 start pulsed 3 cycles after a 10'h1D7 frame begins -> second request ignored; exactly one done pulse.
REQ-032 start held high with GAP=2 -> consecutive frames separated by exactly 2 SS_n-high cycles plus 1 IDLE cycle.
REQ-033 rst asserted during SHIFT_IN of a 10'h3FF frame -> SS_n=1, busy=0, rd_data=8'h00 next cycle; no done pulse.

Source files
------------

// File: rtl/spi_master.sv
// SPI master for a single slave sharing the system clock.
// Sends a 10-bit frame {cmd[1:0], payload[7:0]} MSB first behind a lead bit.
// For rd-data frames (cmd 11) it waits MISO_DLY cycles and shifts in one byte.
// SS_n is released for GAP cycles between frames.
module spi_master #(
  parameter int unsigned MISO_DLY = 1,
  parameter int unsigned GAP      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_SHIFT_OUT = 3'd2,
    ST_WAIT      = 3'd3,
    ST_SHIFT_IN  = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  // Last value of the per-state cycle counter in each timed state.
  localparam logic [3:0] OUT_LAST  = 4'd9;
  localparam logic [3:0] IN_LAST   = 4'd7;
  localparam logic [3:0] WAIT_LAST = (MISO_DLY == 0) ? 4'd0 : 4'(MISO_DLY - 1);
  localparam logic [3:0] GAP_LAST  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        is_rd;
  logic [9:0]  mosi_sr;
  logic [7:0]  miso_sr;

  // State register and per-state cycle counter (cleared on every state change).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == ST_IDLE) begin
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Next-state decode; a start while busy is simply never looked at.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        state_nxt = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        if (cnt == OUT_LAST) begin
          if (!is_rd)             state_nxt = ST_GAP;
          else if (MISO_DLY == 0) state_nxt = ST_SHIFT_IN;
          else                    state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) state_nxt = ST_SHIFT_IN;
      end
      ST_SHIFT_IN: begin
        if (cnt == IN_LAST) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so pins move on rising edges.
  always_comb begin
    busy     = (state != ST_IDLE);
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    done     = 1'b0;
    rd_valid = 1'b0;
    unique case (state)
      ST_CMD, ST_SHIFT_OUT: begin
        SS_n = 1'b0;
        MOSI = mosi_sr[9];
      end
      ST_WAIT, ST_SHIFT_IN: begin
        SS_n = 1'b0;
      end
      ST_GAP: begin
        done     = (cnt == 4'd0);
        rd_valid = (cnt == 4'd0) && is_rd;
      end
      default: begin
        SS_n = 1'b1;
      end
    endcase
  end

  // Shift registers: the frame is captured at acceptance so later cmd_data
  // changes cannot disturb it; the lead (CMD) cycle shows bit 9 without shifting.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      mosi_sr <= cmd_data;
    end else if (state == ST_SHIFT_OUT) begin
      mosi_sr <= {mosi_sr[8:0], 1'b0};
    end
    if (state == ST_SHIFT_IN) begin
      miso_sr <= {miso_sr[6:0], MISO};
    end
  end

  // Frame-type flag and received byte; rd_data updates only at the 8th sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_rd   <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      if (state == ST_IDLE && start) begin
        is_rd <= (cmd_data[9:8] == 2'b11);
      end
      if (state == ST_SHIFT_IN && cnt == IN_LAST) begin
        rd_data <= {miso_sr[6:0], MISO};
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master with a simple slave model.
module tb_spi_master;

  localparam int DLY = 1;
  localparam int GP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] cmd_data = 10'h000;
  logic       MISO = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;

  always #5 clk = ~clk;

  spi_master #(.MISO_DLY(DLY), .GAP(GP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd_data (cmd_data),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  typedef struct {
    logic [9:0]  cmd;
    int          len;
    logic [31:0] mosi;
    bit          rdv;
    logic [7:0]  rdd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rem = 0;
  logic [7:0]  slave_byte = 8'h00;
  logic [7:0]  last_rd = 8'h00;
  bit          rst_pending = 1'b0;
  int          cur_len = 0;
  logic [31:0] cur_mosi = 32'h0;
  int          low_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // SS_n-low length of a frame: lead bit + 10 bits, plus wait and 8 bits for reads.
  function automatic int frame_len(input logic [9:0] c);
    return (c[9:8] == 2'b11) ? 11 + DLY + 8 : 11;
  endfunction

  // Drive one cycle of inputs and advance the reference model at the edge.
  task automatic step(input bit s, input logic [9:0] cd, input logic [7:0] sb, input bit r);
    exp_t e;
    start    = s;
    cmd_data = cd;
    rst      = r;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      rem     = 0;
      last_rd = 8'h00;
    end else if (rem == 0 && s) begin
      e.cmd  = cd;
      e.len  = frame_len(cd);
      e.mosi = {21'b0, cd[9], cd} << (e.len - 11);
      e.rdv  = (cd[9:8] == 2'b11);
      if (e.rdv) begin
        slave_byte = sb;
        last_rd    = sb;
      end
      e.rdd = last_rd;
      exp_q.push_back(e);
      rem = e.len + GP;
    end else if (rem > 0) begin
      rem--;
    end
    #1;
  endtask

  // Slave: presents its byte MSB first once the master starts listening; noise otherwise.
  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (low_cnt >= 11 + DLY && low_cnt < 19 + DLY)
        MISO = slave_byte[7 - (low_cnt - 11 - DLY)];
      else
        MISO = 1'($urandom);
      low_cnt++;
    end else begin
      low_cnt = 0;
      MISO    = 1'($urandom);
    end
  end

  // Monitor: captures each SS_n-low window and checks it when done appears.
  always @(negedge clk) begin
    exp_t e;
    if (rst_pending) begin
      chk("reset_ss_n", SS_n, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_mosi", MOSI, 0);
      cur_len  = 0;
      cur_mosi = 0;
    end else begin
      chk("busy", busy, (rem != 0));
      chk("rd_valid_only_with_done", rd_valid & ~done, 0);
      if (rem == 0) begin
        chk("idle_ss_n", SS_n, 1);
        chk("idle_mosi", MOSI, 0);
        chk("idle_done", done, 0);
      end
      if (SS_n === 1'b0) begin
        cur_mosi = {cur_mosi[30:0], MOSI};
        cur_len++;
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ss_low_cycles", cur_len, e.len);
          chk("mosi_stream", cur_mosi, e.mosi);
          chk("done_ss_n", SS_n, 1);
          chk("rd_valid", rd_valid, e.rdv);
          chk("rd_data", rd_data, e.rdd);
        end
        cur_len  = 0;
        cur_mosi = 0;
      end
    end
    rst_pending = rst;
  end

  initial begin
    step(0, 10'h000, 8'h00, 1);
    step(0, 10'h000, 8'h00, 1);
    repeat (3) step(0, 10'h000, 8'h00, 0);

    // Write-address frame; cmd_data churns while it runs.
    step(1, 10'h0AB, 8'h00, 0);
    repeat (20) step(0, 10'($urandom), 8'h00, 0);

    // Read-data frame, slave answers A5.
    step(1, 10'h352, 8'hA5, 0);
    repeat (26) step(0, 10'($urandom), 8'h00, 0);

    // Second start three cycles into a frame must be dropped.
    step(1, 10'h1D7, 8'h00, 0);
    step(0, 10'h000, 8'h00, 0);
    step(0, 10'h000, 8'h00, 0);
    step(1, 10'h3C3, 8'h5A, 0);
    repeat (20) step(0, 10'h000, 8'h00, 0);

    // start held high: back-to-back frames with random words.
    for (int i = 0; i < 90; i++) step(1, 10'($urandom), 8'($urandom), 0);
    repeat (25) step(0, 10'h000, 8'h00, 0);

    // Reset in the middle of the byte being shifted in.
    step(1, 10'h3FF, 8'h3C, 0);
    repeat (14) step(0, 10'h000, 8'h00, 0);
    step(0, 10'h000, 8'h00, 1);
    repeat (5) step(0, 10'h000, 8'h00, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 6) == 0, 10'($urandom), 8'($urandom), ($urandom % 200) == 0);
    end
    repeat (40) step(0, 10'h000, 8'h00, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
